mips_mc_controller: RTL and testbench

Multicycle MIPS control unit: the driving end of the ALU control interface. It sequences each instruction through fetch, decode, execute, memory and writeback cycles, and emits every datapath enable and mux select. It also generates the 3-bit ALU operation code consumed by the ALU. It sits beside the datapath: opcode/funct from the instruction register and the ALU `zero` flag in, control strobes out.

---
 rtl/mips_mc_controller.sv | 174 +++++++++++++++++
 tb/tb_mips_mc_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with ALU operation decode
module mips_mc_controller #(
    parameter int OP_WIDTH         = 6,
    parameter int FUNCT_WIDTH      = 6,
    parameter int ALUControl_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [OP_WIDTH-1:0]         Op,
    input  logic [FUNCT_WIDTH-1:0]      Funct,
    input  logic                        zero,
    output logic [ALUControl_WIDTH-1:0] ALUControl,
    output logic                        ALUSrcA,
    output logic [1:0]                  ALUSrcB,
    output logic [1:0]                  PCSrc,
    output logic                        IorD,
    output logic                        IRWrite,
    output logic                        MemWrite,
    output logic                        RegWrite,
    output logic                        RegDst,
    output logic                        MemtoReg,
    output logic                        PCEn
);

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

    localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'b100000);
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'b100010);
    localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'b100100);
    localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'b100101);
    localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'b101010);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    state_t state_q, state_d;

    logic [1:0] alu_op;
    logic       pc_write;
    logic       branch;
    logic [2:0] alu_ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Unrecognised opcodes fall back to FETCH so the FSM can never wedge.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        alu_op   = 2'b00;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE:  ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD:   IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:  RegWrite = 1'b1;
            S_JEX: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // zero is consumed combinationally; the datapath samples PCEn at the edge.
    assign PCEn = pc_write | (branch & zero);

    always_comb begin
        alu_ctl = 3'b010;
        case (alu_op)
            2'b01: alu_ctl = 3'b110;
            2'b10: begin
                case (Funct)
                    FN_ADD:  alu_ctl = 3'b010;
                    FN_SUB:  alu_ctl = 3'b110;
                    FN_AND:  alu_ctl = 3'b000;
                    FN_OR:   alu_ctl = 3'b001;
                    FN_SLT:  alu_ctl = 3'b111;
                    default: alu_ctl = 3'b010;
                endcase
            end
            default: alu_ctl = 3'b010;
        endcase
    end

    assign ALUControl = ALUControl_WIDTH'(alu_ctl);

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed self-checking bench for mips_mc_controller
module tb_mips_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       zero;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn;

    int checks = 0;
    int errors = 0;

    mips_mc_controller #(
        .OP_WIDTH(6),
        .FUNCT_WIDTH(6),
        .ALUControl_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Op(Op),
        .Funct(Funct),
        .zero(zero),
        .ALUControl(ALUControl),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc),
        .IorD(IorD),
        .IRWrite(IRWrite),
        .MemWrite(MemWrite),
        .RegWrite(RegWrite),
        .RegDst(RegDst),
        .MemtoReg(MemtoReg),
        .PCEn(PCEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn}
    logic [14:0] obs;
    assign obs = {ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite,
                  MemWrite, RegWrite, RegDst, MemtoReg, PCEn};

    localparam logic [14:0] E_FETCH  = {3'b010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [14:0] E_DECODE = {3'b010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMADR = {3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMRD  = {3'b010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMWB  = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [14:0] E_MEMWR  = {3'b010, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_ALUWB  = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [14:0] E_ADDIEX = {3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_ADDIWB = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_JEX    = {3'b010, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    function automatic logic [14:0] e_exec(input logic [2:0] alu);
        return {alu, 1'b1, 2'b00, 2'b00, 7'b0};
    endfunction

    function automatic logic [14:0] e_beq(input logic z);
        return {3'b110, 1'b1, 2'b00, 2'b01, 6'b0, z};
    endfunction

    task automatic test_reset();
        logic [14:0] exp [4];
        rst_n = 1'b0;
        Op    = 6'b000000;
        Funct = 6'b100000;
        zero  = 1'b0;
        #3;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL reset_low: got %b expected %b", obs, E_FETCH);
        end
        @(negedge clk); #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", obs, E_FETCH);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, E_FETCH);
        end
        exp = '{E_DECODE, e_exec(3'b010), E_ALUWB, E_FETCH};
        foreach (exp[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_rtype step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_lw();
        logic [14:0] exp [5];
        exp = '{E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        Op = 6'b100011;
        foreach (exp[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL lw step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [14:0] exp [4];
        exp = '{E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        Op = 6'b101011;
        foreach (exp[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL sw step %0d: got %b expected %b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_rtype_sweep();
        logic [5:0]  fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        logic [2:0]  alu [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
        logic [14:0] exp [4];
        Op = 6'b000000;
        foreach (fn[k]) begin
            Funct = fn[k];
            exp = '{E_DECODE, e_exec(alu[k]), E_ALUWB, E_FETCH};
            foreach (exp[i]) begin
                @(negedge clk); #1;
                checks++;
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL rtype funct=%b step %0d: got %b expected %b", fn[k], i, obs, exp[i]);
                end
            end
        end
    endtask

    task automatic test_beq();
        logic z;
        Op = 6'b000100;
        for (int t = 0; t < 2; t++) begin
            z    = (t == 0);
            zero = z;
            @(negedge clk); #1;
            checks++;
            if (obs !== E_DECODE) begin
                errors++;
                $display("FAIL beq_decode z=%0b: got %b expected %b", z, obs, E_DECODE);
            end
            @(negedge clk); #1;
            checks++;
            if (obs !== e_beq(z)) begin
                errors++;
                $display("FAIL beq_ex z=%0b: got %b expected %b", z, obs, e_beq(z));
            end
            zero = ~z;
            #1;
            checks++;
            if (PCEn !== ~z) begin
                errors++;
                $display("FAIL beq_zero_toggle: got %b expected %b", PCEn, ~z);
            end
            zero = 1'b0;
            @(negedge clk); #1;
            checks++;
            if (obs !== E_FETCH) begin
                errors++;
                $display("FAIL beq_return z=%0b: got %b expected %b", z, obs, E_FETCH);
            end
        end
    endtask

    task automatic test_addi_j_unknown();
        logic [14:0] exp_addi [4];
        logic [14:0] exp_j    [3];
        logic [14:0] exp_unk  [2];
        exp_addi = '{E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH};
        exp_j    = '{E_DECODE, E_JEX, E_FETCH};
        exp_unk  = '{E_DECODE, E_FETCH};
        Op = 6'b001000;
        foreach (exp_addi[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp_addi[i]) begin
                errors++;
                $display("FAIL addi step %0d: got %b expected %b", i, obs, exp_addi[i]);
            end
        end
        Op = 6'b000010;
        foreach (exp_j[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp_j[i]) begin
                errors++;
                $display("FAIL j step %0d: got %b expected %b", i, obs, exp_j[i]);
            end
        end
        Op = 6'b111111;
        foreach (exp_unk[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp_unk[i]) begin
                errors++;
                $display("FAIL unknown_op step %0d: got %b expected %b", i, obs, exp_unk[i]);
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [14:0] exp_pre  [3];
        logic [14:0] exp_post [5];
        exp_pre  = '{E_DECODE, E_MEMADR, E_MEMRD};
        exp_post = '{E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        Op = 6'b100011;
        foreach (exp_pre[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp_pre[i]) begin
                errors++;
                $display("FAIL abort_pre step %0d: got %b expected %b", i, obs, exp_pre[i]);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL abort_async: got %b expected %b", obs, E_FETCH);
        end
        @(negedge clk); #1;
        checks++;
        if (RegWrite !== 1'b0 || obs !== E_FETCH) begin
            errors++;
            $display("FAIL abort_held: got %b expected %b", obs, E_FETCH);
        end
        rst_n = 1'b1;
        foreach (exp_post[i]) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== exp_post[i]) begin
                errors++;
                $display("FAIL abort_restart step %0d: got %b expected %b", i, obs, exp_post[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype_sweep();
        test_beq();
        test_addi_j_unknown();
        test_reset_mid_lw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
